// File: rtl/tile_sequencer.sv
// tile_sequencer: control sequencer for an N x N systolic matmul tile engine.
// Latency: loads/err pulse 1 cycle after accept; a matmul completes 4N+1+act cycles after accept.
// Backpressure: instr_ready is low while a matmul is in flight; loads, NOPs and illegal ops never stall.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   instr_valid/ready/op/act/tag  instruction handshake; op/act/tag sampled on accept
//   load_l, load_r                one-cycle dripper load strobes
//   arr_clr                       one-cycle accumulator clear at the start of a matmul
//   feed_en, feed_idx             skewed feed phase, feed_idx = 0..3N-3
//   drain_en, drain_idx, add_en   dispatcher drain, drain_idx = 0..N-1, add_en = drain && bias
//   act_en                        ReLU enable, held for the whole matmul when act was latched
//   agg_we, agg_idx               aggregator write, drain stream delayed by 1+act cycles
//   busy, done, done_tag, err     matmul in flight, completion pulse with tag, illegal-op pulse
//   perf_clr, perf_busy, perf_ops optional saturating performance counters (SEQ_PERF_EN)
//
// Optional feature macro: SEQ_PERF_EN adds the performance counter ports and logic.

module tile_sequencer #(
    parameter int N    = 4,
    parameter int TAGW = 4,
    localparam int CW  = $clog2(3 * N),
    localparam int DW  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic            instr_act,
    input  logic [TAGW-1:0] instr_tag,
    output logic            load_l,
    output logic            load_r,
    output logic            arr_clr,
    output logic            feed_en,
    output logic [CW-1:0]   feed_idx,
    output logic            drain_en,
    output logic [DW-1:0]   drain_idx,
    output logic            add_en,
    output logic            act_en,
    output logic            agg_we,
    output logic [DW-1:0]   agg_idx,
    output logic            busy,
    output logic            done,
    output logic [TAGW-1:0] done_tag,
    output logic            err
`ifdef SEQ_PERF_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     perf_busy,
    output logic [15:0]     perf_ops
`endif
);

    localparam logic [3:0] OP_LOADL = 4'd1;
    localparam logic [3:0] OP_LOADR = 4'd2;
    localparam logic [3:0] OP_MM    = 4'd3;
    localparam logic [3:0] OP_MMB   = 4'd4;

    // Terminal counts for the feed and drain phases.
    localparam logic [CW-1:0] FEED_LAST  = CW'(3 * N - 3);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic            bias_q;
    logic            act_q;
    logic [TAGW-1:0] tag_q;

    logic            load_l_q;
    logic            load_r_q;
    logic            err_q;

    // Drain stream delayed by one and two cycles; agg_we taps stage 1 or 2
    // depending on whether the activation stage adds a cycle.
    logic            dr_en1_q, dr_en2_q;
    logic [DW-1:0]   dr_idx1_q, dr_idx2_q;

    logic            accept;
    logic            is_mm;
    logic [CW-1:0]   flush_last;

    assign accept     = instr_valid && (state_q == S_IDLE);
    assign is_mm      = (instr_op == OP_MM) || (instr_op == OP_MMB);
    assign flush_last = act_q ? CW'(1) : CW'(0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: one shared phase counter, cleared on every phase
    // change so each phase starts counting from zero.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mm) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                // Wait for the delayed drain stream to leave the aggregator
                // write port before declaring the op complete.
                if (cnt_q == flush_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode strobes, per-op latches and the drain delay line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            load_l_q  <= 1'b0;
            load_r_q  <= 1'b0;
            err_q     <= 1'b0;
            bias_q    <= 1'b0;
            act_q     <= 1'b0;
            tag_q     <= '0;
            dr_en1_q  <= 1'b0;
            dr_en2_q  <= 1'b0;
            dr_idx1_q <= '0;
            dr_idx2_q <= '0;
        end else begin
            load_l_q <= accept && (instr_op == OP_LOADL);
            load_r_q <= accept && (instr_op == OP_LOADR);
            err_q    <= accept && (instr_op > OP_MMB);
            if (accept && is_mm) begin
                bias_q <= (instr_op == OP_MMB);
                act_q  <= instr_act;
                tag_q  <= instr_tag;
            end
            dr_en1_q  <= drain_en;
            dr_idx1_q <= drain_idx;
            dr_en2_q  <= dr_en1_q;
            dr_idx2_q <= dr_idx1_q;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        load_l      = load_l_q;
        load_r      = load_r_q;
        err         = err_q;
        arr_clr     = (state_q == S_CLEAR);
        feed_en     = (state_q == S_FEED);
        feed_idx    = feed_en ? cnt_q : '0;
        drain_en    = (state_q == S_DRAIN);
        drain_idx   = drain_en ? cnt_q[DW-1:0] : '0;
        add_en      = drain_en && bias_q;
        act_en      = busy && act_q;
        agg_we      = act_q ? dr_en2_q : dr_en1_q;
        agg_idx     = '0;
        if (agg_we) begin
            agg_idx = act_q ? dr_idx2_q : dr_idx1_q;
        end
        done        = done_q;
        done_tag    = done_q ? tag_q : '0;
    end

`ifdef SEQ_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters; a clear beats a same-cycle count.
    // ------------------------------------------------------------------
    logic [31:0] perf_busy_q;
    logic [15:0] perf_ops_q;

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_busy_q <= '0;
            perf_ops_q  <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 16'd1;
            end
        end
    end

    assign perf_busy = perf_busy_q;
    assign perf_ops  = perf_ops_q;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: randomized and directed stimulus for tile_sequencer.
// Latency: expected strobes are timestamped from the accept cycle by a timeline model.
// Backpressure: the driver only counts an accept when the model says the sequencer is idle.

module tb_tile_sequencer;

    localparam int N    = 4;
    localparam int TAGW = 4;
    localparam int CW   = $clog2(3 * N);
    localparam int DW   = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int N2   = 2;
    localparam int CW2  = $clog2(3 * N2);
    localparam int DW2  = ($clog2(N2) > 1) ? $clog2(N2) : 1;

    logic clk;
    logic rst;

    // Main DUT (N=4)
    logic            instr_valid, instr_ready, instr_act;
    logic [3:0]      instr_op;
    logic [TAGW-1:0] instr_tag;
    logic            load_l, load_r, arr_clr, feed_en, drain_en, add_en, act_en;
    logic            agg_we, busy, done, err;
    logic [CW-1:0]   feed_idx;
    logic [DW-1:0]   drain_idx, agg_idx;
    logic [TAGW-1:0] done_tag;

    // Second DUT (N=2)
    logic            v2, rdy2, act2;
    logic [3:0]      op2;
    logic [TAGW-1:0] tag2;
    logic            ll2, lr2, clr2, fe2, de2, ae2, acte2, aw2, busy2, done2, err2;
    logic [CW2-1:0]  fidx2;
    logic [DW2-1:0]  didx2, aidx2;
    logic [TAGW-1:0] dtag2;

`ifdef SEQ_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_busy, p2_busy;
    logic [15:0] perf_ops, p2_ops;
`endif

    tile_sequencer #(.N(N), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_act(instr_act), .instr_tag(instr_tag),
        .load_l(load_l), .load_r(load_r), .arr_clr(arr_clr),
        .feed_en(feed_en), .feed_idx(feed_idx),
        .drain_en(drain_en), .drain_idx(drain_idx), .add_en(add_en), .act_en(act_en),
        .agg_we(agg_we), .agg_idx(agg_idx),
        .busy(busy), .done(done), .done_tag(done_tag), .err(err)
`ifdef SEQ_PERF_EN
        , .perf_clr(perf_clr), .perf_busy(perf_busy), .perf_ops(perf_ops)
`endif
    );

    tile_sequencer #(.N(N2), .TAGW(TAGW)) dut2 (
        .clk(clk), .rst(rst),
        .instr_valid(v2), .instr_ready(rdy2), .instr_op(op2),
        .instr_act(act2), .instr_tag(tag2),
        .load_l(ll2), .load_r(lr2), .arr_clr(clr2),
        .feed_en(fe2), .feed_idx(fidx2),
        .drain_en(de2), .drain_idx(didx2), .add_en(ae2), .act_en(acte2),
        .agg_we(aw2), .agg_idx(aidx2),
        .busy(busy2), .done(done2), .done_tag(dtag2), .err(err2)
`ifdef SEQ_PERF_EN
        , .perf_clr(perf_clr), .perf_busy(p2_busy), .perf_ops(p2_ops)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each accepted op expands into a timeline of
    // expected strobes; kinds 0..7 below.
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    ev_t   evq [8][$];
    string kn [8] = '{"load_l", "load_r", "err", "arr_clr", "feed", "drain", "agg", "done"};
    int    free_cyc = 0;   // first cycle in which the sequencer is idle again
    bit    act_lat  = 1'b0;
    bit    mon_en   = 1'b0;

    task automatic push(input int k, input int t, input int idx);
        ev_t e;
        e.cyc = t;
        e.idx = idx;
        evq[k].push_back(e);
    endtask

    task automatic model_accept(input int t, input int op, input bit a, input int tg);
        int l;
        if (op == 1) push(0, t + 1, 0);
        else if (op == 2) push(1, t + 1, 0);
        else if (op >= 5) push(2, t + 1, 0);
        else if (op == 3 || op == 4) begin
            l = a ? 2 : 1;
            push(3, t + 1, 0);
            for (int i = 0; i < 3 * N - 2; i++) push(4, t + 2 + i, i);
            for (int i = 0; i < N; i++) push(5, t + 3 * N + i, i * 2 + ((op == 4) ? 1 : 0));
            for (int i = 0; i < N; i++) push(6, t + 3 * N + l + i, i);
            push(7, t + 4 * N + l, tg);
            free_cyc = t + 4 * N + l;
            act_lat  = a;
        end
    endtask

    task automatic drive(input bit v, input int op, input bit a, input int tg);
        int tgm;
        @(negedge clk);
        #1;
        tgm         = tg % (1 << TAGW);
        rst         = 1'b0;
        instr_valid = v;
        instr_op    = 4'(op);
        instr_act   = a;
        instr_tag   = TAGW'(tgm);
        if (v && (cyc >= free_cyc)) model_accept(cyc, op, a, tgm);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst         = 1'b1;
        instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) evq[k].delete();
        free_cyc = cyc + 1;
        act_lat  = 1'b0;
    endtask

    task automatic idle_until_free();
        while (cyc < free_cyc) drive(0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the timeline whenever a strobe appears
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        bit [7:0] s;
        int       v [8];
        ev_t      e;
        if (mon_en) begin
            s    = {done, agg_we, drain_en, feed_en, arr_clr, err, load_r, load_l};
            v[0] = 0; v[1] = 0; v[2] = 0; v[3] = 0;
            v[4] = int'(feed_idx);
            v[5] = int'(drain_idx) * 2 + int'(add_en);
            v[6] = int'(agg_idx);
            v[7] = int'(done_tag);
            for (int k = 0; k < 8; k++) begin
                while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
                    chk({kn[k], "_missing"}, -1, evq[k][0].cyc);
                    void'(evq[k].pop_front());
                end
                if (s[k]) begin
                    if (evq[k].size() == 0) begin
                        chk({kn[k], "_unexpected"}, cyc, -1);
                    end else begin
                        e = evq[k].pop_front();
                        chk({kn[k], "_cycle"}, cyc, e.cyc);
                        if (k >= 4 && e.cyc == cyc) chk({kn[k], "_value"}, v[k], e.idx);
                    end
                end
            end
            chk("instr_ready", int'(instr_ready), int'(cyc >= free_cyc));
            chk("busy", int'(busy), int'(cyc < free_cyc));
            chk("act_en", int'(act_en), int'((cyc < free_cyc) && act_lat));
            chk("add_en_gate", int'(add_en && !drain_en), 0);
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t0, fcnt, dcnt, acnt, done_at, dsum, asum, fmax, other, bcnt, ccnt, xcnt, rlow, dtag;
        int r, op;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 4'd0;
        instr_act   = 1'b0;
        instr_tag   = '0;
        v2 = 1'b0; op2 = 4'd0; act2 = 1'b0; tag2 = '0;
`ifdef SEQ_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        drive(0, 0, 0, 0);

        // Back-to-back loads
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Plain matmul, tag 5
`ifdef SEQ_PERF_EN
        perf_clr = 1'b1;
        drive(0, 0, 0, 0);
        perf_clr = 1'b0;
`endif
        drive(1, 3, 0, 5);
        idle_until_free();
        drive(0, 0, 0, 0);
`ifdef SEQ_PERF_EN
        chk("perf_busy", int'(perf_busy), 4 * N);
        chk("perf_ops", int'(perf_ops), 1);
`endif

        // Bias + ReLU matmul, tag 9
        drive(1, 4, 1, 9);
        idle_until_free();
        drive(0, 0, 0, 0);

        // Valid held high: next op accepted in the done cycle
        for (int i = 0; i < 2 * (4 * N + 2) + 3; i++) drive(1, 3, i % 2, i);
        idle_until_free();
        drive(0, 0, 0, 0);

        // Reset during drain: op aborted, no done
        drive(1, 3, 1, 3);
        t0 = cyc;
        while (cyc < t0 + 3 * N + 1) drive(0, 0, 0, 0);
        mid_reset();
        for (int i = 0; i < 4 * N + 6; i++) drive(0, 0, 0, 0);

        // Illegal opcode
        drive(1, 7, 1, 2);
        drive(0, 0, 0, 0);
        drive(1, 15, 0, 1);
        drive(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 3) op = 0;
            else if (r < 6) op = 1;
            else if (r < 9) op = 2;
            else if (r < 12) op = 3;
            else if (r < 15) op = 4;
            else op = int'($urandom_range(5, 15));
            drive(($urandom_range(0, 3) != 0), op, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)));
        end
        idle_until_free();
        repeat (3) drive(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) chk({kn[k], "_pending"}, evq[k].size(), 0);

        // N=2 instance: one plain matmul
        @(negedge clk);
        #1;
        chk("n2_ready_idle", int'(rdy2), 1);
        v2 = 1'b1; op2 = 4'd3; act2 = 1'b0; tag2 = TAGW'(6);
        fcnt = 0; dcnt = 0; acnt = 0; done_at = -1; dsum = 0; asum = 0; fmax = 0;
        other = 0; bcnt = 0; ccnt = 0; xcnt = 0; rlow = 0; dtag = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) v2 = 1'b0;
            fcnt += int'(fe2);
            dcnt += int'(de2);
            acnt += int'(aw2);
            bcnt += int'(busy2);
            ccnt += int'(clr2);
            rlow += int'(!rdy2);
            other += int'(ll2) + int'(lr2) + int'(err2);
            xcnt += int'(ae2) + int'(acte2);
            if (fe2 && int'(fidx2) > fmax) fmax = int'(fidx2);
            if (de2) dsum += int'(didx2);
            if (aw2) asum += int'(aidx2);
            if (done2) begin
                done_at = k;
                dtag    = int'(dtag2);
            end
        end
        chk("n2_feed_cycles", fcnt, 3 * N2 - 2);
        chk("n2_feed_idx_max", fmax, 3 * N2 - 3);
        chk("n2_drain_cycles", dcnt, N2);
        chk("n2_drain_idx_sum", dsum, N2 * (N2 - 1) / 2);
        chk("n2_agg_cycles", acnt, N2);
        chk("n2_agg_idx_sum", asum, N2 * (N2 - 1) / 2);
        chk("n2_done_cycle", done_at, 4 * N2 + 1);
        chk("n2_done_tag", dtag, 6);
        chk("n2_busy_cycles", bcnt, 4 * N2);
        chk("n2_ready_low", rlow, 4 * N2);
        chk("n2_clr_cycles", ccnt, 1);
        chk("n2_stray_strobes", other + xcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Parametrised control sequencer for an N×N systolic matmul tile engine. It accepts opcodes over a valid/ready handshake and generates every phase strobe and index for the operand drippers, the systolic array, the dispatcher, the activation stage and the aggregator: load pulses, array clear, skewed feed, drain with optional bias add, and result write-back. It completes each matmul with a tagged done pulse.

Parameters:
N, 4, array dimension; legal range 2..16.
TAGW, 4, width of the instruction tag returned on done.
Derived localparam CW = $clog2(3*N), width of feed_idx.
Derived localparam DW = max(1, $clog2(N)), width of drain_idx and agg_idx.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
instr_valid  in  1  instruction offered.
instr_ready  out  1  sequencer can accept an instruction.
instr_op  in  4  opcode: 0 NOP, 1 LOADL, 2 LOADR, 3 MATMUL, 4 MATMUL_BIAS, 5..15 illegal.
instr_act  in  1  apply ReLU to results; used by ops 3/4 only.
instr_tag  in  TAGW  tag, latched on accept.
load_l  out  1  1-cycle left-dripper load strobe.
load_r  out  1  1-cycle right-dripper load strobe.
arr_clr  out  1  systolic array accumulator clear.
feed_en  out  1  dripper feed active.
feed_idx  out  CW  feed step, 0..3N-3.
drain_en  out  1  dispatcher drain active.
drain_idx  out  DW  dispatcher row, 0..N-1.
add_en  out  1  dispatcher bias add; equals drain_en && bias.
act_en  out  1  ReLU enable; held for the whole op when act is latched.
agg_we  out  1  aggregator write enable.
agg_idx  out  DW  aggregator row, 0..N-1.
busy  out  1  matmul in flight.
done  out  1  1-cycle matmul completion pulse.
done_tag  out  TAGW  tag of the completing op; valid while done=1.
err  out  1  1-cycle illegal-opcode pulse.

Behaviour:
- Reset: all outputs 0, except instr_ready=1 from the first non-reset cycle. State=IDLE; latched bias/act/tag cleared. Reset mid-operation aborts the op on the next edge with no done pulse. Reset has priority over every other input.
- Handshake: instr_ready = (state==IDLE). Accept occurs on a clock edge with instr_valid && instr_ready. Ops are decoded only on accept.
- NOP: accepted; no effect.
- LOADL/LOADR: load_l or load_r pulses in the cycle after accept. The block stays IDLE, so back-to-back loads are accepted every cycle.
- Illegal opcode: accepted; err pulses in the next cycle; no other effect.
- MATMUL/MATMUL_BIAS: on accept (edge T), latch bias=(op==4), act=instr_act, tag. Phase timing:
  - CLEAR at T+1: arr_clr=1 for 1 cycle.
  - FEED at T+2..T+3N-1: 3N-2 cycles; feed_idx counts 0..3N-3.
  - DRAIN at T+3N..T+4N-1: N cycles; drain_idx counts 0..N-1; add_en=bias.
  - FLUSH: L cycles, where L = 1+act.
  - agg_we is high for N cycles starting at T+3N+L; agg_idx counts 0..N-1. This is the drain stream delayed by L through a shift register.
  - done and done_tag at T+4N+L. The state is already IDLE in that cycle, so instr_ready=1 and a new op may be accepted in the done cycle.
- busy is high from T+1 through T+4N+L-1. act_en = busy && act.
- Counters never wrap within a phase. Every phase transition is on a terminal-count compare.
- Worked example, N=4, act=0: clear T+1, feed T+2..T+11, drain T+12..T+15, agg_we T+13..T+16, done T+17. With act=1: agg_we T+14..T+17, done T+18.

Optional Feature:
SEQ_PERF_EN.
- Defined: adds input perf_clr (1b) and outputs perf_busy (32b) and perf_ops (16b).
  - perf_busy counts busy cycles; perf_ops counts done pulses.
  - Both saturate at all-ones.
  - Both are cleared by rst or perf_clr. perf_clr wins over an increment in the same cycle.
- Undefined: these ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
1. N=4, reset, then LOADL then LOADR on consecutive cycles -> load_l pulses at T+1, load_r at T+2; instr_ready stays 1; busy stays 0.
2. N=4, MATMUL act=0 tag=5 -> arr_clr at T+1; feed_idx 0..9 over T+2..T+11; drain_idx 0..3 over T+12..T+15 with add_en=0; agg_idx 0..3 over T+13..T+16; done=1 with done_tag=5 at T+17.
3. N=4, MATMUL_BIAS act=1 tag=9 -> add_en=1 on all 4 drain cycles; act_en high for the whole op; agg_we over T+14..T+17; done at T+18 with done_tag=9.
4. Hold instr_valid with MATMUL continuously -> second accept lands on the first op's done cycle; second arr_clr appears the next cycle; instr_ready=0 during busy.
5. Assert rst during DRAIN -> next cycle all outputs 0, instr_ready=1, and no done pulse ever appears.
6. op=7 -> err pulses 1 cycle, no other output toggles. With N=2: feed 4 cycles, drain 2 cycles. With SEQ_PERF_EN: after one act=0 matmul at N=4, perf_busy=16 and perf_ops=1.
